// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage downstream of execute.
//   Ports:
//     clk, reset_n            clock / async active-low reset
//     alu_result_i, rs2_data_i, rd_i, ctrl_*_i
//                             instruction from execute (held by upstream while stall_o)
//     mem_req_o/we/addr/be/wdata, mem_gnt_i, mem_rvalid_i, mem_rdata_i
//                             single-port data memory handshake
//     stall_o                 pipeline hold while an access is outstanding
//     wb_data_o, wb_rd_o, wb_reg_write_o
//                             registered writeback / MEM forwarding source
//     misalign_o              one-cycle pulse for misaligned or illegal-width ld/st
package PARAMS_pkg;
  parameter int WD_SIZE        = 32;
  parameter int INSTR_REG_SIZE = 5;
  parameter int FUNCT3_SIZE    = 3;
endpackage

module stage_mem
  import PARAMS_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  input  logic                      ctrl_ld_i,
  input  logic                      ctrl_st_i,
  input  logic                      ctrl_reg_write_i,
  input  logic [FUNCT3_SIZE-1:0]    ctrl_mem_width_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [WD_SIZE-1:0]        mem_addr_o,
  output logic [3:0]                mem_be_o,
  output logic [WD_SIZE-1:0]        mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [WD_SIZE-1:0]        mem_rdata_i,
  output logic                      stall_o,
  output logic [WD_SIZE-1:0]        wb_data_o,
  output logic [INSTR_REG_SIZE-1:0] wb_rd_o,
  output logic                      wb_reg_write_o,
  output logic                      misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state_q, state_d;

  // Holding registers for the access in flight
  logic [WD_SIZE-1:0]        addr_q, sdata_q;
  logic [INSTR_REG_SIZE-1:0] rd_q;
  logic [FUNCT3_SIZE-1:0]    width_q;
  logic                      ld_q, regw_q;

  logic [WD_SIZE-1:0]        wb_data_q;
  logic [INSTR_REG_SIZE-1:0] wb_rd_q;
  logic                      wb_regw_q, misalign_q;

  logic is_mem, width_ok, align_ok, accept, fault;
  logic [3:0]         be_d;
  logic [WD_SIZE-1:0] wdata_d, ld_data;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;

  // ---------------- decode of the incoming instruction ----------------
  assign is_mem = ctrl_ld_i | ctrl_st_i;

  always_comb begin
    width_ok = 1'b0;
    if (ctrl_ld_i) begin
      case (ctrl_mem_width_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: width_ok = 1'b1;
        default:                                width_ok = 1'b0;
      endcase
    end else begin
      case (ctrl_mem_width_i)
        3'b000, 3'b001, 3'b010: width_ok = 1'b1;
        default:                width_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (ctrl_mem_width_i[1:0])
      2'b01:   align_ok = ~alu_result_i[0];
      2'b10:   align_ok = (alu_result_i[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign accept = (state_q == S_IDLE) & is_mem & width_ok & align_ok;
  assign fault  = (state_q == S_IDLE) & is_mem & ~(width_ok & align_ok);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)       state_d = S_REQ;
      S_REQ:   if (mem_gnt_i)    state_d = ld_q ? S_WAIT : S_IDLE;
      S_WAIT:  if (mem_rvalid_i) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Request fields come straight from holding registers, so they stay
  // stable for as long as the memory withholds the grant.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    stall_o     = (state_q != S_IDLE);
    if (state_q == S_REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ~ld_q;
      mem_addr_o  = {addr_q[WD_SIZE-1:2], 2'b00};
      mem_be_o    = be_d;
      mem_wdata_o = wdata_d;
    end
  end

  // Byte lanes: same enable rule for loads and stores
  always_comb begin
    case (width_q[1:0])
      2'b00:   be_d = 4'b0001 << addr_q[1:0];
      2'b01:   be_d = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  always_comb begin
    case (width_q[1:0])
      2'b00:   wdata_d = {4{sdata_q[7:0]}};
      2'b01:   wdata_d = {2{sdata_q[15:0]}};
      default: wdata_d = sdata_q;
    endcase
  end

  // Load alignment and extension; width_q[2] selects zero-extension
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_b = mem_rdata_i[7:0];
      2'b01:   lane_b = mem_rdata_i[15:8];
      2'b10:   lane_b = mem_rdata_i[23:16];
      default: lane_b = mem_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (width_q)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_data = {24'd0, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_data = {16'd0, lane_h};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // ---------------- datapath / writeback registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      width_q    <= '0;
      ld_q       <= 1'b0;
      regw_q     <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regw_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      // write enable and fault flag are single-cycle pulses
      wb_regw_q  <= 1'b0;
      misalign_q <= fault;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= alu_result_i;
            sdata_q <= rs2_data_i;
            rd_q    <= rd_i;
            width_q <= ctrl_mem_width_i;
            ld_q    <= ctrl_ld_i;
            regw_q  <= ctrl_reg_write_i;
          end else if (!is_mem) begin
            wb_data_q <= alu_result_i;
            wb_rd_q   <= rd_i;
            wb_regw_q <= ctrl_reg_write_i & (rd_i != '0);
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            wb_data_q <= ld_data;
            wb_rd_q   <= rd_q;
            wb_regw_q <= regw_q & (rd_q != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_data_o      = wb_data_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_reg_write_o = wb_regw_q;
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed scenarios plus randomized
// ALU / load / store traffic checked against an arithmetic reference model.
module tb_stage_mem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] alu_result_i, rs2_data_i, mem_rdata_i;
  logic [4:0]  rd_i;
  logic        ctrl_ld_i, ctrl_st_i, ctrl_reg_write_i, mem_gnt_i, mem_rvalid_i;
  logic [2:0]  ctrl_mem_width_i;
  logic        mem_req_o, mem_we_o, stall_o, wb_reg_write_o, misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  wb_rd_o;
  logic [109:0] all_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stage_mem dut (
    .clk(clk), .reset_n(reset_n),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .ctrl_ld_i(ctrl_ld_i), .ctrl_st_i(ctrl_st_i), .ctrl_reg_write_i(ctrl_reg_write_i),
    .ctrl_mem_width_i(ctrl_mem_width_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .wb_reg_write_o(wb_reg_write_o), .misalign_o(misalign_o)
  );

  assign all_o = {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o,
                  wb_data_o, wb_rd_o, wb_reg_write_o, misalign_o};

  // ---------------- reference model ----------------
  function automatic int sz(logic [2:0] w);
    return 1 << w[1:0];
  endfunction

  function automatic bit legal(bit ld, logic [2:0] w, logic [31:0] a);
    bit ok;
    ok = ld ? (w inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (w inside {3'd0, 3'd1, 3'd2});
    return ok && ((int'(a[1:0]) % sz(w)) == 0);
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] w, logic [31:0] a);
    int m;
    m = ((1 << sz(w)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] w, logic [31:0] d);
    int s;
    longint v, r;
    s = sz(w);
    v = longint'(d) % (longint'(1) << (8 * s));
    r = 0;
    for (int i = 0; i < 4 / s; i++) r += v << (8 * s * i);
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] w, logic [31:0] a, logic [31:0] rd);
    int s;
    longint v;
    s = sz(w);
    v = (longint'(rd) >> (8 * a[1:0])) % (longint'(1) << (8 * s));
    if (!w[2] && s < 4 && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  typedef struct {
    logic req, we, stall, regw_during, req_wait, stall_wait, wb_regw, stall_end;
    logic [31:0] addr, wdata, wb_data;
    logic [3:0] be;
    logic [4:0] wb_rd;
    int stable;
  } obs_t;

  task automatic drive(input logic [31:0] a, d, input logic [4:0] rd, input logic ld, st, rw,
                       input logic [2:0] w);
    alu_result_i = a; rs2_data_i = d; rd_i = rd;
    ctrl_ld_i = ld; ctrl_st_i = st; ctrl_reg_write_i = rw; ctrl_mem_width_i = w;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues one legal ld/st, grants after gw extra cycles, returns data after
  // rvd extra cycles, and presents (and holds) a following ALU op meanwhile.
  task automatic mem_op(input logic ld, input logic [2:0] w, input logic [31:0] a, d,
                        input logic [4:0] rd, input logic rw, input int gw, rvd,
                        input logic [31:0] rdat, nalu, input logic [4:0] nrd, input logic nrw,
                        output obs_t o);
    o = '{default: 0};
    drive(a, d, rd, ld, !ld, rw, w);
    tick();
    o.req = mem_req_o; o.we = mem_we_o; o.addr = mem_addr_o; o.be = mem_be_o;
    o.wdata = mem_wdata_o; o.stall = stall_o;
    drive(nalu, $urandom, nrd, 1'b0, 1'b0, nrw, 3'($urandom));
    for (int i = 0; i <= gw; i++) begin
      if (i == gw) mem_gnt_i = 1'b1;
      mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;  // ignored outside WAIT
      if (mem_req_o && mem_we_o == o.we && mem_addr_o == o.addr && mem_be_o == o.be &&
          mem_wdata_o == o.wdata) o.stable++;
      o.regw_during |= wb_reg_write_o;
      tick();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    if (ld) begin
      o.req_wait = mem_req_o; o.stall_wait = stall_o;
      for (int i = 0; i <= rvd; i++) begin
        o.regw_during |= wb_reg_write_o;
        if (i == rvd) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdat; end
        else mem_rdata_i = $urandom;
        tick();
      end
      mem_rvalid_i = 1'b0;
    end
    o.wb_data = wb_data_o; o.wb_rd = wb_rd_o; o.wb_regw = wb_reg_write_o; o.stall_end = stall_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_chk++; if (all_o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_o); end
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  task automatic test_alu();
    drive(32'h1234, 0, 5'd5, 0, 0, 1, 3'd0);
    tick();
    n_chk++; if ({wb_data_o, wb_rd_o, wb_reg_write_o, stall_o} !== {32'h1234, 5'd5, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL alu_pass: got %h/%0d/%b/%b want 1234/5/1/0", wb_data_o, wb_rd_o, wb_reg_write_o, stall_o); end
    drive(32'h99, 0, 5'd0, 0, 0, 1, 3'd0);
    tick();
    n_chk++; if ({wb_data_o, wb_reg_write_o} !== {32'h99, 1'b0}) begin
      n_fail++; $display("FAIL alu_rd0: got %h/%b want 99/0", wb_data_o, wb_reg_write_o); end
  endtask

  task automatic test_lb();
    obs_t o;
    mem_op(1, 3'b000, 32'h103, 0, 5'd4, 1, 0, 0, 32'h80FF_0000, 32'h0, 5'd0, 0, o);
    n_chk++; if ({o.req, o.we, o.addr, o.be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
      n_fail++; $display("FAIL lb_req: got %b/%b/%h/%b want 1/0/100/1000", o.req, o.we, o.addr, o.be); end
    n_chk++; if ({o.wb_data, o.wb_rd, o.wb_regw, o.stall_end} !== {32'hFFFF_FF80, 5'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL lb_data: got %h/%0d/%b/%b want ffffff80/4/1/0", o.wb_data, o.wb_rd, o.wb_regw, o.stall_end); end
    mem_op(1, 3'b100, 32'h103, 0, 5'd4, 1, 0, 0, 32'h80FF_0000, 32'h0, 5'd0, 0, o);
    n_chk++; if (o.wb_data !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu_data: got %h want 00000080", o.wb_data); end
    tick();
  endtask

  task automatic test_sh();
    obs_t o;
    mem_op(0, 3'b001, 32'h102, 32'hABCD_1234, 5'd6, 0, 2, 0, 0, 32'h0, 5'd0, 0, o);
    n_chk++; if ({o.req, o.we, o.addr, o.be, o.wdata} !== {1'b1, 1'b1, 32'h100, 4'b1100, 32'h1234_1234}) begin
      n_fail++; $display("FAIL sh_req: got %b/%b/%h/%b/%h want 1/1/100/1100/12341234", o.req, o.we, o.addr, o.be, o.wdata); end
    n_chk++; if (o.stable !== 3) begin n_fail++; $display("FAIL sh_hold: got %0d cycles want 3", o.stable); end
    n_chk++; if ({o.stall_end, o.wb_regw, o.regw_during} !== 3'b000) begin
      n_fail++; $display("FAIL sh_end: got stall %b regw %b/%b want 0/0/0", o.stall_end, o.wb_regw, o.regw_during); end
    tick();
  endtask

  task automatic test_misalign();
    drive(32'h101, 0, 5'd3, 1, 0, 1, 3'b010);
    tick();
    n_chk++; if ({mem_req_o, stall_o, misalign_o, wb_reg_write_o} !== 4'b0010) begin
      n_fail++; $display("FAIL lw_misalign: got req %b stall %b mis %b regw %b want 0/0/1/0", mem_req_o, stall_o, misalign_o, wb_reg_write_o); end
    drive(32'h100, 0, 5'd3, 0, 1, 0, 3'b100);  // illegal store width
    tick();
    n_chk++; if ({mem_req_o, stall_o, misalign_o} !== 3'b001) begin
      n_fail++; $display("FAIL st_badwidth: got req %b stall %b mis %b want 0/0/1", mem_req_o, stall_o, misalign_o); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_chk++; if ({mem_req_o, misalign_o} !== 2'b00) begin
      n_fail++; $display("FAIL misalign_pulse: got req %b mis %b want 0/0", mem_req_o, misalign_o); end
  endtask

  task automatic test_rd0();
    obs_t o;
    mem_op(1, 3'b010, 32'h200, 0, 5'd0, 1, 1, 1, 32'hDEAD_BEEF, 32'h55, 5'd7, 1, o);
    n_chk++; if ({o.wb_data, o.wb_regw, o.regw_during} !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ld_rd0: got %h/%b/%b want deadbeef/0/0", o.wb_data, o.wb_regw, o.regw_during); end
    tick();
    n_chk++; if ({wb_data_o, wb_rd_o, wb_reg_write_o} !== {32'h55, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL add_after_ld: got %h/%0d/%b want 55/7/1", wb_data_o, wb_rd_o, wb_reg_write_o); end
  endtask

  task automatic test_reset_wait();
    drive(32'h40, 0, 5'd3, 1, 0, 1, 3'b010);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
    n_chk++; if ({mem_req_o, stall_o} !== 2'b01) begin
      n_fail++; $display("FAIL wait_state: got req %b stall %b want 0/1", mem_req_o, stall_o); end
    reset_n = 1'b0; #1;
    n_chk++; if (all_o !== '0) begin n_fail++; $display("FAIL reset_in_wait: got %h want 0", all_o); end
    tick(); reset_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111; tick(); mem_rvalid_i = 1'b0;
    n_chk++; if ({wb_data_o, wb_reg_write_o, stall_o} !== {32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rvalid_after_reset: got %h/%b/%b want 0/0/0", wb_data_o, wb_reg_write_o, stall_o); end
    drive(32'h77, 0, 5'd9, 0, 0, 1, 0);
    tick();
    n_chk++; if ({wb_data_o, wb_rd_o, wb_reg_write_o} !== {32'h77, 5'd9, 1'b1}) begin
      n_fail++; $display("FAIL alu_after_reset: got %h/%0d/%b want 77/9/1", wb_data_o, wb_rd_o, wb_reg_write_o); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 2);
      logic [31:0] a = $urandom, d = $urandom, rdat = $urandom, nalu = $urandom;
      logic [4:0] rd = 5'($urandom), nrd = 5'($urandom);
      logic rw = 1'($urandom), nrw = 1'($urandom), ld = (kind == 1);
      logic [2:0] w = $urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      int gw = $urandom_range(0, 3), rvd = $urandom_range(0, 2);
      if ($urandom_range(0, 1)) a[1:0] = 2'b00;
      if (kind == 0) begin
        drive(a, d, rd, 0, 0, rw, w);
        tick();
        n_chk++; if ({wb_data_o, wb_rd_o, wb_reg_write_o, stall_o} !== {a, rd, rw && rd != 0, 1'b0}) begin
          n_fail++; $display("FAIL rnd_alu[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/0", it, wb_data_o, wb_rd_o, wb_reg_write_o, stall_o, a, rd, rw && rd != 0); end
      end else if (!legal(ld, w, a)) begin
        drive(a, d, rd, ld, !ld, rw, w);
        tick();
        n_chk++; if ({mem_req_o, stall_o, misalign_o, wb_reg_write_o} !== 4'b0010) begin
          n_fail++; $display("FAIL rnd_fault[%0d]: got req %b stall %b mis %b regw %b want 0/0/1/0", it, mem_req_o, stall_o, misalign_o, wb_reg_write_o); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
      end else begin
        mem_op(ld, w, a, d, rd, rw, gw, rvd, rdat, nalu, nrd, nrw, o);
        n_chk++; if ({o.req, o.we, o.addr, o.be, o.stall} !== {1'b1, !ld, a & ~32'h3, exp_be(w, a), 1'b1}) begin
          n_fail++; $display("FAIL rnd_req[%0d]: got %b/%b/%h/%b/%b want 1/%b/%h/%b/1", it, o.req, o.we, o.addr, o.be, o.stall, !ld, a & ~32'h3, exp_be(w, a)); end
        n_chk++; if ({o.stable, o.regw_during, o.stall_end} !== {gw + 1, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL rnd_hold[%0d]: got %0d/%b/%b want %0d/0/0", it, o.stable, o.regw_during, o.stall_end, gw + 1); end
        if (ld) begin
          n_chk++; if ({o.req_wait, o.stall_wait, o.wb_data, o.wb_rd, o.wb_regw} !== {1'b0, 1'b1, exp_load(w, a, rdat), rd, rw && rd != 0}) begin
            n_fail++; $display("FAIL rnd_load[%0d]: got %b/%b/%h/%0d/%b want 0/1/%h/%0d/%b", it, o.req_wait, o.stall_wait, o.wb_data, o.wb_rd, o.wb_regw, exp_load(w, a, rdat), rd, rw && rd != 0); end
        end else begin
          n_chk++; if ({o.wdata, o.wb_regw} !== {exp_wdata(w, d), 1'b0}) begin
            n_fail++; $display("FAIL rnd_store[%0d]: got %h/%b want %h/0", it, o.wdata, o.wb_regw, exp_wdata(w, d)); end
        end
        tick();
        n_chk++; if ({wb_data_o, wb_rd_o, wb_reg_write_o} !== {nalu, nrd, nrw && nrd != 0}) begin
          n_fail++; $display("FAIL rnd_next[%0d]: got %h/%0d/%b want %h/%0d/%b", it, wb_data_o, wb_rd_o, wb_reg_write_o, nalu, nrd, nrw && nrd != 0); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_misalign();
    test_rd0();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage directly downstream of the execute stage. Takes the registered ALU result, store data, destination register and load/store controls from execute. Performs byte/half/word loads and stores against a single-port data memory through a request/grant/response handshake, aligning and sign-extending load data. Stalls the pipeline while an access is outstanding, and presents registered writeback data that also serves as the MEM-stage forwarding source.

## Interface
Parameters (package constants from PARAMS_pkg):
- WD_SIZE, 32, data/address width
- INSTR_REG_SIZE, 5, register index width
- FUNCT3_SIZE, 3, memory width code width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- alu_result_i  in  WD_SIZE  effective address (ld/st) or ALU result (others)
- rs2_data_i  in  WD_SIZE  store data
- rd_i  in  INSTR_REG_SIZE  destination register
- ctrl_ld_i / ctrl_st_i  in  1  load / store
- ctrl_reg_write_i  in  1  instruction writes rd
- ctrl_mem_width_i  in  FUNCT3_SIZE  RISC-V funct3 width code
- mem_req_o  out  1  access request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  WD_SIZE  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  WD_SIZE  lane-aligned store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  WD_SIZE  load word
- stall_o  out  1  pipeline hold
- wb_data_o  out  WD_SIZE  writeback / forwarding data
- wb_rd_o  out  INSTR_REG_SIZE  writeback register
- wb_reg_write_o  out  1  writeback enable
- misalign_o  out  1  one-cycle fault pulse

## Operation
- FSM states: IDLE, REQ, WAIT. stall_o = (state != IDLE).
- IDLE, no ld/st: register alu_result_i→wb_data_o, rd_i→wb_rd_o, ctrl_reg_write_i & (rd_i!=0)→wb_reg_write_o.
- IDLE, ld or st, legal and aligned: latch address, store data, rd, width, ld/st into holding registers. Go to REQ. wb_reg_write_o←0 that cycle.
- Legal widths: ld 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; st 000/001/010.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal width:
  - no request, stay IDLE;
  - misalign_o=1 and wb_reg_write_o=0 next cycle.
- REQ: mem_req_o=1; mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o driven from holding registers and held stable until gnt.
  - SB: be=1<<addr[1:0], wdata={4{byte}}.
  - SH: be=addr[1]?1100:0011, wdata={2{half}}.
  - SW: be=1111.
  - Load: be per width, same rule as stores.
  - On mem_gnt_i: store→IDLE; load→WAIT.
- WAIT: mem_req_o=0. On mem_rvalid_i, select byte/half by addr[1:0] and sign- or zero-extend per width. Result→wb_data_o, held rd→wb_rd_o, wb_reg_write_o=held reg_write & (rd!=0). Go to IDLE.
- mem_rvalid_i in IDLE/REQ is ignored.
- Upstream holds its outputs constant while stall_o=1. Inputs are sampled only in IDLE.

## Timing
- Reset (async, immediate): state IDLE; all outputs 0, including mem_req_o and stall_o; holding registers 0. Reset during REQ/WAIT abandons the access; a later rvalid is ignored.
- Non-memory instruction at inputs in cycle N: wb_* valid in cycle N+1.
- Load accepted cycle N:
  - REQ and stall_o=1 from N+1;
  - gnt at cycle G moves to WAIT at G+1;
  - rvalid at cycle R gives IDLE, stall_o=0 and wb_* valid at R+1.
  - Minimum latency with gnt at N+1 and rvalid at N+2: data at N+3.
- Store accepted cycle N with gnt in cycle G: IDLE at G+1; wb_reg_write_o=0 throughout.
- Instruction following a memory op is presented by upstream at N+1 and held. It is sampled in the first IDLE cycle after completion.
- wb_* hold their value while stalled, except wb_reg_write_o, which is 0 in every cycle other than the single write cycle.
- Back-to-back memory ops are legal: a second ld/st sampled in the first IDLE cycle re-enters REQ next cycle.

## Test plan
- ALU pass-through: alu_result_i=0x1234, rd_i=5, reg_write=1 at N → N+1: wb_data_o=0x1234, wb_rd_o=5, wb_reg_write_o=1, stall_o=0.
- LB sign-extend: addr 0x103, gnt immediately, rdata 0x80FF_0000 → mem_addr_o=0x100, be=1000, wb_data_o=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH: addr 0x102, rs2=0xABCD_1234, gnt after 3 cycles → mem_req_o held 3 cycles with be=1100, wdata=0x1234_1234, mem_we_o=1. stall_o drops the cycle after gnt; no writeback.
- Misaligned LW at 0x101 → no mem_req_o, misalign_o pulse 1 cycle, wb_reg_write_o=0, stall_o stays 0.
- Load to rd=0 with rdata 0xDEAD_BEEF → wb_reg_write_o=0; a following ADD result appears in the cycle after the load completes.
- Reset asserted in WAIT, then rvalid arrives → outputs 0 immediately, rvalid ignored, next ALU op completes normally.
